// File: rtl/pcle_pkg.sv
// rtl/pcle_pkg.sv - shared types and constants for the pcle reload timer
package pcle_pkg;

    localparam int PCLE_CNT_W = 8;
    localparam logic [PCLE_CNT_W-1:0] PCLE_TC_VAL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } pcle_state_e;

    typedef struct packed {
        logic i;
        logic j;
        logic k;
    } pcle_ctl_t;

    localparam pcle_ctl_t CTL_LOAD  = '{i: 1'b1, j: 1'b0, k: 1'b0};
    localparam pcle_ctl_t CTL_COUNT = '{i: 1'b0, j: 1'b1, k: 1'b0};
    localparam pcle_ctl_t CTL_CLEAR = '{i: 1'b0, j: 1'b0, k: 1'b0};

endpackage

// File: rtl/pcle_cl_comb.sv
// rtl/pcle_cl_comb.sv - 8-bit parallel-load counter next-state function
module pcle_cl_comb
    import pcle_pkg::*;
(
    input  logic [PCLE_CNT_W-1:0] q,
    input  logic [PCLE_CNT_W-1:0] d,
    input  pcle_ctl_t             ctl,
    output logic [PCLE_CNT_W-1:0] q_next,
    output logic                  t
);

    // i loads, j=0 clears, j=1/k=0 counts, j=1/k=1 holds
    always_comb begin
        q_next = q;
        if (ctl.i) begin
            q_next = d;
        end else if (!ctl.j) begin
            q_next = '0;
        end else if (!ctl.k) begin
            q_next = q + 1'b1;
        end
    end

    assign t = !ctl.i && ctl.j && !ctl.k && (q == PCLE_TC_VAL);

endmodule

// File: rtl/pcle_timer.sv
// rtl/pcle_timer.sv - programmable reload timer with one-shot and periodic modes
module pcle_timer
    import pcle_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk_pad,
    input  logic              rst_pad,
    input  logic              cfg_valid_pad,
    output logic              cfg_ready_pad,
    input  logic [CNT_W-1:0]  cfg_reload_pad,
    input  logic              cfg_oneshot_pad,
    input  logic              start_pad,
    input  logic              stop_pad,
    input  logic              clear_pad,
    output logic [CNT_W-1:0]  count_pad,
    output logic              tc_pulse_pad,
    output logic [WRAP_W-1:0] wrap_cnt_pad,
    output logic              busy_pad,
    output logic              done_pad
);

    pcle_state_e       state_q, state_d;
    pcle_ctl_t         ctl;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  reload_q;
    logic              oneshot_q;
    logic [WRAP_W-1:0] wrap_q;
    logic              tc_q, tc_d;
    logic              cnt_en, wrap_clr, wrap_inc, accept, term;
    logic              t_unused;

    pcle_cl_comb u_cl_comb (
        .q      (count_q),
        .d      (reload_q),
        .ctl    (ctl),
        .q_next (count_d),
        .t      (t_unused)
    );

    assign term = (count_q == PCLE_TC_VAL);

    always_comb begin
        state_d  = state_q;
        ctl      = CTL_COUNT;
        cnt_en   = 1'b0;
        tc_d     = 1'b0;
        wrap_inc = 1'b0;
        wrap_clr = 1'b0;
        accept   = 1'b0;
        if (clear_pad) begin
            state_d  = ST_IDLE;
            ctl      = CTL_CLEAR;
            cnt_en   = 1'b1;
            wrap_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cfg_valid_pad) begin
                        accept   = 1'b1;
                        wrap_clr = 1'b1;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ctl     = CTL_LOAD;
                    cnt_en  = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    cnt_en = 1'b1;
                    if (term) begin
                        tc_d     = 1'b1;
                        wrap_inc = 1'b1;
                        // one-shot lets the counter wrap to zero; periodic reloads
                        if (oneshot_q) begin
                            state_d = ST_DONE;
                        end else begin
                            ctl = CTL_LOAD;
                            if (stop_pad) state_d = ST_HOLD;
                        end
                    end else if (stop_pad) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (start_pad) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            oneshot_q <= 1'b0;
            wrap_q    <= '0;
            tc_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            if (cnt_en) count_q <= count_d;
            if (wrap_clr) begin
                wrap_q <= '0;
            end else if (wrap_inc && (wrap_q != '1)) begin
                wrap_q <= wrap_q + 1'b1;
            end
            if (accept) begin
                reload_q  <= cfg_reload_pad;
                oneshot_q <= cfg_oneshot_pad;
            end
        end
    end

    assign cfg_ready_pad = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !rst_pad;
    assign count_pad     = count_q;
    assign tc_pulse_pad  = tc_q;
    assign wrap_cnt_pad  = wrap_q;
    assign busy_pad      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done_pad      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pcle_timer.sv
// tb/tb_pcle_timer.sv - scoreboard bench for pcle_timer against a behavioural model
module tb_pcle_timer;

    logic       clk = 1'b0;
    logic       rst_pad = 1'b1;
    logic       cfg_valid_pad = 1'b0;
    logic       cfg_ready_pad;
    logic [7:0] cfg_reload_pad = '0;
    logic       cfg_oneshot_pad = 1'b0;
    logic       start_pad = 1'b0;
    logic       stop_pad = 1'b0;
    logic       clear_pad = 1'b0;
    logic [7:0] count_pad;
    logic       tc_pulse_pad;
    logic [7:0] wrap_cnt_pad;
    logic       busy_pad;
    logic       done_pad;

    always #5 clk = ~clk;

    pcle_timer #(.CNT_W(8), .WRAP_W(8)) dut (
        .clk_pad         (clk),
        .rst_pad         (rst_pad),
        .cfg_valid_pad   (cfg_valid_pad),
        .cfg_ready_pad   (cfg_ready_pad),
        .cfg_reload_pad  (cfg_reload_pad),
        .cfg_oneshot_pad (cfg_oneshot_pad),
        .start_pad       (start_pad),
        .stop_pad        (stop_pad),
        .clear_pad       (clear_pad),
        .count_pad       (count_pad),
        .tc_pulse_pad    (tc_pulse_pad),
        .wrap_cnt_pad    (wrap_cnt_pad),
        .busy_pad        (busy_pad),
        .done_pad        (done_pad)
    );

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_HOLD, M_DONE} mode_e;
    typedef struct {
        int count;
        bit tc;
        int wrap;
        bit busy;
        bit done;
        bit rdy_st;
    } exp_t;

    exp_t  sbq[$];
    mode_e m_st = M_IDLE;
    int    m_cnt = 0;
    int    m_wrap = 0;
    int    m_r = 0;
    bit    m_os = 1'b0;
    bit    m_tc = 1'b0;
    int    checks = 0;
    int    failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // The model reasons in terms of periods: count advances modulo 256,
    // a wrap past 0xFF is the terminal event, after which periodic mode restarts at R.
    task automatic step(input bit v, input int r, input bit os, input bit sta,
                        input bit sto, input bit clr, input bit rst);
        exp_t e;
        int   nxt;
        cfg_valid_pad   = v;
        cfg_reload_pad  = r[7:0];
        cfg_oneshot_pad = os;
        start_pad       = sta;
        stop_pad        = sto;
        clear_pad       = clr;
        rst_pad         = rst;
        m_tc = 1'b0;
        if (clr || rst) begin
            m_st = M_IDLE; m_cnt = 0; m_wrap = 0;
        end else if ((m_st == M_IDLE || m_st == M_DONE) && v) begin
            m_r = r % 256; m_os = os; m_wrap = 0; m_st = M_LOAD;
        end else if (m_st == M_LOAD) begin
            m_cnt = m_r; m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            nxt = (m_cnt + 1) % 256;
            if (nxt == 0) begin
                m_tc   = 1'b1;
                m_wrap = (m_wrap + 1 > 255) ? 255 : m_wrap + 1;
                if (m_os) m_st = M_DONE;
                else nxt = m_r;
            end
            m_cnt = nxt;
            if (sto && m_st == M_RUN) m_st = M_HOLD;
        end else if (m_st == M_HOLD && sta) begin
            m_st = M_RUN;
        end
        e.count  = m_cnt;
        e.tc     = m_tc;
        e.wrap   = m_wrap;
        e.busy   = (m_st == M_LOAD) || (m_st == M_RUN) || (m_st == M_HOLD);
        e.done   = (m_st == M_DONE);
        e.rdy_st = (m_st == M_IDLE) || (m_st == M_DONE);
        @(posedge clk);
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int r, input bit os);
        step(1, r, os, 0, 0, 0, 0);
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (!(m_st == M_RUN && m_cnt == target) && n < 600) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL run_until: got no count %0h expected reachable within 600 cycles", target);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("count", 32'(count_pad), 32'(e.count));
            chk("tc_pulse", 32'(tc_pulse_pad), 32'(e.tc));
            chk("wrap_cnt", 32'(wrap_cnt_pad), 32'(e.wrap));
            chk("busy", 32'(busy_pad), 32'(e.busy));
            chk("done", 32'(done_pad), 32'(e.done));
            chk("cfg_ready", 32'(cfg_ready_pad), 32'(e.rdy_st & ~rst_pad));
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        cfg(8'hFC, 0);
        idle(20);

        step(0, 0, 0, 0, 0, 1, 0);
        cfg(8'hFE, 1);
        idle(8);

        cfg(8'h10, 0);
        run_until(8'h20);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(5);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(4);

        run_until(8'h70);
        step(1, 8'h55, 1, 0, 0, 0, 0);
        run_until(8'h80);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(3);

        cfg(8'hFF, 0);
        idle(300);
        step(0, 0, 0, 0, 0, 1, 0);

        cfg(8'h30, 0);
        run_until(8'h33);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        cfg(8'hFC, 0);
        run_until(8'hFF);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(6);
        step(0, 0, 0, 0, 0, 1, 0);
        cfg(8'hF0, 1);
        run_until(8'hFF);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = ($urandom % 2 == 0) ? (32'hF0 | ($urandom % 16)) : ($urandom % 256);
            step(($urandom % 8) == 0, r, $urandom % 2,
                 ($urandom % 6) == 0, ($urandom % 10) == 0,
                 ($urandom % 200) == 0, ($urandom % 300) == 0);
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
